// File: rtl/ad_udp_pkt_gen.sv
// ad_udp_pkt_gen
// ---------------------------------------------------------------------------
// Upstream feeder for the UDP/GMII transmit stage. ADC sample bytes are
// buffered in a single-clock FIFO. A small FSM decides when a packet is ready:
// either a full PKT_LEN payload is buffered, or partial data has sat in the
// FIFO for TIMEOUT cycles. It then issues a one-cycle start pulse together
// with the byte count. Payload bytes are popped on the transmitter's tx_req
// strobe with a one-cycle registered read latency. The next packet is only
// launched after the transmitter reports frame completion on tx_done.
//
// Handshake: ad_valid is a push-only strobe with no back-pressure (a byte
// offered while full is dropped and counted). tx_req is a pull strobe with
// no back-pressure (a strobe on an empty FIFO returns 0 and sets underflow).
// tx_start_en and tx_done are single-cycle pulses.
//
// Ports:
//   clk          system clock (GMII TX domain)
//   rst          synchronous reset, active-high
//   ad_data      ADC sample byte
//   ad_valid     ad_data is valid this cycle
//   tx_req       transmitter payload read strobe
//   tx_done      transmitter frame-complete pulse
//   tx_start_en  one-cycle start pulse to the transmitter
//   tx_byte_num  payload length of the current packet
//   tx_data      payload byte, registered
//   fifo_level   current FIFO occupancy
//   drop_cnt     saturating count of samples dropped on full
//   underflow    sticky: tx_req seen while the FIFO was empty
//
// The FSM state is held in state_q (type state_e) for external checkers.
// ---------------------------------------------------------------------------
module ad_udp_pkt_gen #(
    parameter int DEPTH_LOG2 = 11,
    parameter int PKT_LEN    = 1024,
    parameter int TIMEOUT    = 125000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            ad_data,
    input  logic                  ad_valid,
    input  logic                  tx_req,
    input  logic                  tx_done,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           drop_cnt,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [LW-1:0] PKT_LEN_L  = LW'(PKT_LEN);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en;
    logic                  rd_en;

    always_comb begin
        // Both decisions use the level at the start of the cycle, so a
        // same-cycle pop never makes room for a write offered while full.
        wr_en       = ad_valid && (level_q < DEPTH_L);
        rd_en       = tx_req && (level_q != '0);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tx_data_d   = tx_data_q;
        drop_cnt_d  = drop_cnt_q;
        underflow_d = underflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (ad_valid && !wr_en && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // A strobe on an empty FIFO deliberately zeroes the data output so
        // the transmitter never resends a stale byte.
        if (tx_req) begin
            tx_data_d = rd_en ? mem_q[rd_ptr_q] : 8'h00;
            if (!rd_en) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Storage array carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= ad_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tx_data_q   <= '0;
            drop_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tx_data_q   <= tx_data_d;
            drop_cnt_q  <= drop_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Packet FSM
    // -----------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [15:0]   byte_num_q, byte_num_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_num_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_num_q <= byte_num_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_num_d = byte_num_q;
        tmo_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (level_q >= PKT_LEN_L) begin
                    byte_num_d = 16'(PKT_LEN);
                    state_d    = ST_START;
                end else if ((TIMEOUT != 0) && (level_q != '0) && (tmo_q == TMO_LAST)) begin
                    // Short packet: ship whatever is buffered right now.
                    byte_num_d = 16'(level_q);
                    state_d    = ST_START;
                end else if (level_q != '0) begin
                    // Partial data waiting; the counter ages it.
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_start_en = (state_q == ST_START);
    end

    assign tx_byte_num = byte_num_q;
    assign tx_data     = tx_data_q;
    assign fifo_level  = level_q;
    assign drop_cnt    = drop_cnt_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_ad_udp_pkt_gen.sv
// Testbench for ad_udp_pkt_gen. Two instances share clock and reset:
// u_dut (TIMEOUT = 0, flushing disabled) exercises full packets, the FIFO
// boundaries and reset; u_dut_t (TIMEOUT = 100) exercises the short-packet
// flush. A queue model of the FIFO supplies expected bytes and counters.
module tb_ad_udp_pkt_gen;

    localparam int FIFO_DEPTH = 2048;
    localparam int PKT        = 1024;
    localparam int TMO        = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  ad_data;
    logic        ad_valid;
    logic        tx_req;
    logic        tx_done;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [7:0]  tx_data;
    logic [11:0] fifo_level;
    logic [15:0] drop_cnt;
    logic        underflow;

    logic [7:0]  t_ad_data;
    logic        t_ad_valid;
    logic        t_tx_req;
    logic        t_tx_done;
    logic        t_tx_start_en;
    logic [15:0] t_tx_byte_num;
    logic [7:0]  t_tx_data;
    logic [11:0] t_fifo_level;
    logic [15:0] t_drop_cnt;
    logic        t_underflow;

    ad_udp_pkt_gen #(.DEPTH_LOG2(11), .PKT_LEN(PKT), .TIMEOUT(0)) u_dut (
        .clk(clk), .rst(rst),
        .ad_data(ad_data), .ad_valid(ad_valid),
        .tx_req(tx_req), .tx_done(tx_done),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_data(tx_data), .fifo_level(fifo_level),
        .drop_cnt(drop_cnt), .underflow(underflow)
    );

    ad_udp_pkt_gen #(.DEPTH_LOG2(11), .PKT_LEN(PKT), .TIMEOUT(TMO)) u_dut_t (
        .clk(clk), .rst(rst),
        .ad_data(t_ad_data), .ad_valid(t_ad_valid),
        .tx_req(t_tx_req), .tx_done(t_tx_done),
        .tx_start_en(t_tx_start_en), .tx_byte_num(t_tx_byte_num),
        .tx_data(t_tx_data), .fifo_level(t_fifo_level),
        .drop_cnt(t_drop_cnt), .underflow(t_underflow)
    );

    // ---------------- clock / cycle counter / start monitors ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_cnt = 0, start_cyc = -1;
    int t_start_cnt = 0, t_start_cyc = -1;
    always @(negedge clk) begin
        if (tx_start_en === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (t_tx_start_en === 1'b1) begin
            t_start_cnt = t_start_cnt + 1;
            t_start_cyc = cyc;
        end
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_data = 8'h00;
    logic        exp_uf   = 1'b0;
    logic [15:0] exp_drop = 16'h0000;
    int          last_wr_cyc = -1;   // cycle in which the last accepted write was presented

    // One clock of main-DUT stimulus. On return (1 time unit after the
    // edge) the model reflects that edge and registered outputs are stable.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r, input logic dn);
        int pre;
        ad_valid = v; ad_data = d; tx_req = r; tx_done = dn;
        @(posedge clk); #1;
        pre = exp_q.size();
        if (r) begin
            if (pre > 0) exp_data = exp_q.pop_front();
            else begin
                exp_data = 8'h00;
                exp_uf   = 1'b1;
            end
        end
        if (v) begin
            if (pre < FIFO_DEPTH) begin
                exp_q.push_back(d);
                last_wr_cyc = cyc - 1;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop = exp_drop + 16'd1;
            end
        end
        ad_valid = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    endtask

    task automatic model_reset;
        exp_q.delete();
        exp_data = 8'h00;
        exp_uf   = 1'b0;
        exp_drop = 16'h0000;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tx_start_en !== 1'b0) $display("FAIL rst_start: got %0b expected 0", tx_start_en); else n_pass++;
        n_checks++; if (tx_byte_num !== 16'd0) $display("FAIL rst_byte_num: got %0d expected 0", tx_byte_num); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %0h expected 0", tx_data); else n_pass++;
        n_checks++; if (fifo_level !== 12'd0) $display("FAIL rst_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d expected 0", drop_cnt); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL rst_underflow: got %0b expected 0", underflow); else n_pass++;
        n_checks++; if (t_fifo_level !== 12'd0) $display("FAIL rst_t_level: got %0d expected 0", t_fifo_level); else n_pass++;
        n_checks++; if (t_tx_start_en !== 1'b0) $display("FAIL rst_t_start: got %0b expected 0", t_tx_start_en); else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_packet;
        int base = start_cnt;
        for (int i = 0; i < PKT; i++) begin
            repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        end
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (start_cnt - base !== 1) $display("FAIL full_start_count: got %0d expected 1", start_cnt - base); else n_pass++;
        n_checks++; if (start_cyc !== last_wr_cyc + 2) $display("FAIL full_start_latency: got cycle %0d expected %0d", start_cyc, last_wr_cyc + 2); else n_pass++;
        n_checks++; if (tx_byte_num !== 16'(PKT)) $display("FAIL full_byte_num: got %0d expected %0d", tx_byte_num, PKT); else n_pass++;
        n_checks++; if (fifo_level !== 12'(exp_q.size())) $display("FAIL full_level: got %0d expected %0d", fifo_level, exp_q.size()); else n_pass++;
    endtask

    task automatic test_readout;
        int base = start_cnt;
        for (int i = 0; i < PKT; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (tx_data !== exp_data) $display("FAIL readout_data[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
        end
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (fifo_level !== 12'd0) $display("FAIL readout_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL readout_underflow: got %0b expected 0", underflow); else n_pass++;
        n_checks++; if (start_cnt !== base) $display("FAIL readout_no_restart: got %0d starts expected %0d", start_cnt, base); else n_pass++;
        n_checks++; if (tx_byte_num !== 16'(PKT)) $display("FAIL readout_byte_num_stable: got %0d expected %0d", tx_byte_num, PKT); else n_pass++;
    endtask

    // Refill while still waiting for tx_done, release with tx_done, then a
    // random interleaving of writes and reads.
    task automatic test_back_to_back;
        int base = start_cnt;
        int done_cyc;
        int n;
        for (int i = 0; i < PKT; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (start_cnt !== base) $display("FAIL b2b_no_start_before_done: got %0d starts expected %0d", start_cnt, base); else n_pass++;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        done_cyc = cyc - 1;
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (start_cnt !== base + 1) $display("FAIL b2b_start_after_done: got %0d starts expected %0d", start_cnt, base + 1); else n_pass++;
        n_checks++; if (start_cyc !== done_cyc + 2) $display("FAIL b2b_start_latency: got cycle %0d expected %0d", start_cyc, done_cyc + 2); else n_pass++;
        for (int i = 0; i < 1500; i++) begin
            logic r = 1'($urandom_range(0, 1));
            drive_cycle(($urandom_range(0, 3) == 0), 8'($urandom), r, 1'b0);
            if (r) begin
                n_checks++; if (tx_data !== exp_data) $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
            end
        end
        n_checks++; if (fifo_level !== 12'(exp_q.size())) $display("FAIL b2b_level_mid: got %0d expected %0d", fifo_level, exp_q.size()); else n_pass++;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (tx_data !== exp_data) $display("FAIL b2b_drain[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (fifo_level !== 12'd0) $display("FAIL b2b_level_end: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (start_cnt !== base + 1) $display("FAIL b2b_no_start_empty: got %0d starts expected %0d", start_cnt, base + 1); else n_pass++;
    endtask

    task automatic test_drop;
        int lvl;
        int n;
        for (int i = 0; i < FIFO_DEPTH; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        n_checks++; if (drop_cnt !== exp_drop || exp_drop !== 16'd5) $display("FAIL drop_cnt_5: got %0d expected 5", drop_cnt); else n_pass++;
        n_checks++; if (fifo_level !== 12'(FIFO_DEPTH)) $display("FAIL drop_level_full: got %0d expected %0d", fifo_level, FIFO_DEPTH); else n_pass++;
        // Write and pop together while full: the pop does not rescue the write.
        drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        n_checks++; if (drop_cnt !== 16'd6) $display("FAIL drop_no_rescue: got %0d expected 6", drop_cnt); else n_pass++;
        n_checks++; if (fifo_level !== 12'(FIFO_DEPTH - 1)) $display("FAIL drop_level_after_pop: got %0d expected %0d", fifo_level, FIFO_DEPTH - 1); else n_pass++;
        n_checks++; if (tx_data !== exp_data) $display("FAIL drop_pop_data: got %0h expected %0h", tx_data, exp_data); else n_pass++;
        lvl = exp_q.size();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
            n_checks++; if (tx_data !== exp_data) $display("FAIL simul_data[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
        end
        n_checks++; if (fifo_level !== 12'(lvl)) $display("FAIL simul_level_unchanged: got %0d expected %0d", fifo_level, lvl); else n_pass++;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (tx_data !== exp_data) $display("FAIL drop_drain[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (fifo_level !== 12'd0) $display("FAIL drop_level_end: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL drop_underflow: got %0b expected 0", underflow); else n_pass++;
    endtask

    task automatic test_underflow;
        logic [7:0] b;
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (tx_data !== 8'h00) $display("FAIL uf_data_zero: got %0h expected 0", tx_data); else n_pass++;
        n_checks++; if (underflow !== exp_uf || exp_uf !== 1'b1) $display("FAIL uf_flag: got %0b expected 1", underflow); else n_pass++;
        repeat (5) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (tx_data !== 8'h00) $display("FAIL uf_data_hold: got %0h expected 0", tx_data); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_flag_sticky: got %0b expected 1", underflow); else n_pass++;
        b = 8'($urandom_range(1, 255));
        drive_cycle(1'b1, b, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (tx_data !== b) $display("FAIL uf_then_pop_data: got %0h expected %0h", tx_data, b); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_flag_after_pop: got %0b expected 1", underflow); else n_pass++;
    endtask

    task automatic test_reset_mid_packet;
        int base;
        for (int i = 0; i < PKT; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < PKT - 500; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (tx_data !== exp_data) $display("FAIL mid_data[%0d]: got %0h expected %0h", i, tx_data, exp_data); else n_pass++;
        end
        n_checks++; if (fifo_level !== 12'd500) $display("FAIL mid_level_500: got %0d expected 500", fifo_level); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        base = start_cnt;
        n_checks++; if (tx_start_en !== 1'b0) $display("FAIL mid_rst_start: got %0b expected 0", tx_start_en); else n_pass++;
        n_checks++; if (tx_byte_num !== 16'd0) $display("FAIL mid_rst_byte_num: got %0d expected 0", tx_byte_num); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL mid_rst_data: got %0h expected 0", tx_data); else n_pass++;
        n_checks++; if (fifo_level !== 12'd0) $display("FAIL mid_rst_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL mid_rst_drop: got %0d expected 0", drop_cnt); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL mid_rst_underflow: got %0b expected 0", underflow); else n_pass++;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (5) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (start_cnt !== base) $display("FAIL mid_stray_done: got %0d starts expected %0d", start_cnt, base); else n_pass++;
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (tx_data !== 8'h00) $display("FAIL mid_req_after_rst_data: got %0h expected 0", tx_data); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL mid_req_after_rst_uf: got %0b expected 1", underflow); else n_pass++;
    endtask

    // The FIFO becomes non-empty in the cycle after the first write is
    // presented (w0 + 1). The TIMEOUT-th idle cycle with data is w0 + TMO,
    // where the flush is decided, so the start pulse lands in w0 + TMO + 1.
    task automatic test_timeout;
        logic [7:0] td [10];
        int w0 = 0;
        repeat (200) begin @(posedge clk); #1; end
        n_checks++; if (t_start_cnt !== 0) $display("FAIL tmo_no_start_empty: got %0d starts expected 0", t_start_cnt); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            td[i] = 8'($urandom);
            t_ad_valid = 1'b1; t_ad_data = td[i];
            @(posedge clk); #1;
            if (i == 0) w0 = cyc - 1;
        end
        t_ad_valid = 1'b0;
        repeat (130) begin @(posedge clk); #1; end
        n_checks++; if (t_start_cnt !== 1) $display("FAIL tmo_start_count: got %0d expected 1", t_start_cnt); else n_pass++;
        n_checks++; if (t_start_cyc !== w0 + TMO + 1) $display("FAIL tmo_start_cycle: got %0d expected %0d", t_start_cyc, w0 + TMO + 1); else n_pass++;
        n_checks++; if (t_tx_byte_num !== 16'd10) $display("FAIL tmo_byte_num: got %0d expected 10", t_tx_byte_num); else n_pass++;
        n_checks++; if (t_fifo_level !== 12'd10) $display("FAIL tmo_level: got %0d expected 10", t_fifo_level); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            t_tx_req = 1'b1;
            @(posedge clk); #1;
            t_tx_req = 1'b0;
            n_checks++; if (t_tx_data !== td[i]) $display("FAIL tmo_data[%0d]: got %0h expected %0h", i, t_tx_data, td[i]); else n_pass++;
        end
        t_tx_done = 1'b1;
        @(posedge clk); #1;
        t_tx_done = 1'b0;
        repeat (150) begin @(posedge clk); #1; end
        n_checks++; if (t_start_cnt !== 1) $display("FAIL tmo_no_restart_empty: got %0d expected 1", t_start_cnt); else n_pass++;
        n_checks++; if (t_underflow !== 1'b0) $display("FAIL tmo_underflow: got %0b expected 0", t_underflow); else n_pass++;
    endtask

    initial begin
        ad_valid = 1'b0; ad_data = 8'h00; tx_req = 1'b0; tx_done = 1'b0;
        t_ad_valid = 1'b0; t_ad_data = 8'h00; t_tx_req = 1'b0; t_tx_done = 1'b0;
        test_reset();
        test_full_packet();
        test_readout();
        test_back_to_back();
        test_drop();
        test_underflow();
        test_reset_mid_packet();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
